// File: rtl/ram_pixel_processor_pkg.sv
// Shared types for the pixel block RAM post-processing stage.
// Op encodings, FSM states and default widths.
package ram_pixel_processor_pkg;

   localparam int DEF_ADDR_W = 3;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      OP_PASS = 2'b00,
      OP_INV  = 2'b01,
      OP_ADD  = 2'b10,
      OP_THR  = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/ram_pixel_processor_alu.sv
// pixel_op_alu: combinational point operation on one pixel.
// Shared by later image stages.
module pixel_op_alu
   import ram_pixel_processor_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [DATA_W-1:0] p,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] operand,
   output logic [DATA_W-1:0] result
);

   logic [DATA_W:0] sum;

   always_comb begin
      sum    = {1'b0, p} + {1'b0, operand};
      result = p;
      unique case (op)
         OP_PASS: result = p;
         OP_INV:  result = ~p;
         OP_ADD:  result = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
         OP_THR:  result = (p >= operand) ? '1 : '0;
         default: result = p;
      endcase
   end

endmodule

// File: rtl/ram_pixel_processor.sv
// In-place read/modify/write walk over the pixel block RAM.
// Define PIXEL_MAX_EN to add the max_pixel output.
module ram_pixel_processor
   import ram_pixel_processor_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] operand,
   input  logic              clear_req,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rw,
   output logic              ram_clear,
   output logic [DATA_W-1:0] ram_wdata,
`ifdef PIXEL_MAX_EN
   output logic [DATA_W-1:0] max_pixel,
`endif
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state;
   op_t               op_q;
   logic [DATA_W-1:0] operand_q;
   logic [DATA_W-1:0] result;
   logic              rw_q;

   pixel_op_alu #(.DATA_W(DATA_W)) u_alu (
      .p       (ram_rdata),
      .op      (op_q),
      .operand (operand_q),
      .result  (result)
   );

   // rst masks a pending write combinationally so an abort lands no pixel
   assign ram_rw = rw_q & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         ram_addr  <= '0;
         rw_q      <= 1'b0;
         ram_clear <= 1'b0;
         ram_wdata <= '0;
         op_q      <= OP_PASS;
         operand_q <= '0;
`ifdef PIXEL_MAX_EN
         max_pixel <= '0;
`endif
      end else begin
         done      <= 1'b0;
         ram_clear <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  op_q      <= op_t'(op);
                  operand_q <= operand;
                  ram_addr  <= '0;
                  rw_q      <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_RD;
`ifdef PIXEL_MAX_EN
                  max_pixel <= '0;
`endif
               end else if (clear_req) begin
                  ram_clear <= 1'b1;
               end
            end
            S_RD: state <= S_CAP;
            S_CAP: begin
               ram_wdata <= result;
               rw_q      <= 1'b1;
               state     <= S_WR;
            end
            S_WR: begin
               rw_q <= 1'b0;
`ifdef PIXEL_MAX_EN
               if (ram_wdata > max_pixel)
                  max_pixel <= ram_wdata;
`endif
               if (ram_addr == LAST_ADDR) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  ram_addr <= ram_addr + 1'b1;
                  state    <= S_RD;
               end
            end
            S_DONE: state <= S_IDLE;
            default: begin
               busy  <= 1'b0;
               rw_q  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_pixel_processor.sv
// Bench for ram_pixel_processor: behavioural RAM plus reference model.
// Define PIXEL_MAX_EN to also check max_pixel.
module tb_ram_pixel_processor;

   localparam int AW    = 3;
   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          clear_req;
   logic [1:0]    op;
   logic [DW-1:0] operand;
   logic          busy;
   logic          done;
   logic [AW-1:0] ram_addr;
   logic          ram_rw;
   logic          ram_clear;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
`ifdef PIXEL_MAX_EN
   logic [DW-1:0] max_pixel;
`endif

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] pre [DEPTH];
   logic          pl_en;
   logic [AW-1:0] pl_addr;
   logic [DW-1:0] pl_data;

   int checks = 0;
   int errors = 0;
   int viol   = 0;

   always #5 clk = ~clk;

   ram_pixel_processor dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .operand   (operand),
      .clear_req (clear_req),
      .busy      (busy),
      .done      (done),
      .ram_addr  (ram_addr),
      .ram_rw    (ram_rw),
      .ram_clear (ram_clear),
      .ram_wdata (ram_wdata),
`ifdef PIXEL_MAX_EN
      .max_pixel (max_pixel),
`endif
      .ram_rdata (ram_rdata)
   );

   // synchronous RAM, read-before-write, with a bench-side preload port
   always @(posedge clk) begin
      if (pl_en)
         mem[pl_addr] <= pl_data;
      else if (ram_clear)
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      else if (ram_rw)
         mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (ram_rw && !busy) viol++;
         if (ram_clear && busy) viol++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_op(input logic [1:0] o,
                                            input int p, input int k);
      case (o)
         2'd0:    return DW'(p);
         2'd1:    return DW'(255 - p);
         2'd2:    return (p + k > 255) ? 8'hFF : DW'(p + k);
         default: return (p >= k) ? 8'hFF : 8'h00;
      endcase
   endfunction

   task automatic load_mem();
      for (int i = 0; i < DEPTH; i++) begin
         pl_en   = 1'b1;
         pl_addr = AW'(i);
         pl_data = pre[i];
         @(posedge clk);
         #1;
      end
      pl_en = 1'b0;
   endtask

   task automatic run(input logic [1:0] o, input logic [DW-1:0] k,
                      input int glitch, output int dcyc,
                      output int ndone, output int nbusy);
      op      = o;
      operand = k;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      dcyc  = -1;
      ndone = 0;
      nbusy = 0;
      for (int c = 1; c <= 34; c++) begin
         if (c == glitch) begin
            start     = 1'b1;
            clear_req = 1'b1;
            op        = 2'($urandom);
            operand   = 8'($urandom);
         end else begin
            start     = 1'b0;
            clear_req = 1'b0;
         end
         @(negedge clk);
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            dcyc = c;
         end
         @(posedge clk);
         #1;
      end
      start     = 1'b0;
      clear_req = 1'b0;
   endtask

   task automatic verify(input string tag, input logic [1:0] o,
                         input logic [DW-1:0] k);
      logic [DW-1:0] mx;
      mx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("%s[%0d]", tag, i), 32'(mem[i]),
               32'(ref_op(o, pre[i], k)));
         if (ref_op(o, pre[i], k) > mx) mx = ref_op(o, pre[i], k);
      end
`ifdef PIXEL_MAX_EN
      check({tag, "_max"}, 32'(max_pixel), 32'(mx));
`endif
   endtask

   task automatic timing(input string tag, input int dcyc,
                         input int ndone, input int nbusy);
      check({tag, "_done_cyc"}, dcyc, 25);
      check({tag, "_done_cnt"}, ndone, 1);
      check({tag, "_busy_cnt"}, nbusy, 24);
   endtask

   initial begin
      int dc, nd, nb, cnt, g;
      logic [1:0] o;
      logic [DW-1:0] k;

      rst       = 1'b1;
      start     = 1'b0;
      clear_req = 1'b0;
      op        = '0;
      operand   = '0;
      pl_en     = 1'b0;
      pl_addr   = '0;
      pl_data   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_addr", 32'(ram_addr), 0);
      check("rst_rw", 32'(ram_rw), 0);
      check("rst_clear", 32'(ram_clear), 0);
      check("rst_wdata", 32'(ram_wdata), 0);
`ifdef PIXEL_MAX_EN
      check("rst_max", 32'(max_pixel), 0);
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;

      pre = '{8'h81, 8'hF0, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
      load_mem();
      run(2'b01, 8'h00, 0, dc, nd, nb);
      timing("inv", dc, nd, nb);
      verify("inv", 2'b01, 8'h00);

      load_mem();
      run(2'b10, 8'h20, 0, dc, nd, nb);
      timing("add", dc, nd, nb);
      verify("add", 2'b10, 8'h20);

      load_mem();
      run(2'b11, 8'h80, 0, dc, nd, nb);
      verify("thr80", 2'b11, 8'h80);

      load_mem();
      run(2'b11, 8'h81, 0, dc, nd, nb);
      check("thr_eq", 32'(mem[0]), 32'hFF);

      load_mem();
      run(2'b01, 8'h00, 10, dc, nd, nb);
      timing("glitch", dc, nd, nb);
      verify("glitch", 2'b01, 8'h00);

      // abort during the write of pixel 2
      load_mem();
      op      = 2'b01;
      operand = 8'h00;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_rw", 32'(ram_rw), 0);
      check("abort_busy", 32'(busy), 0);
      cnt = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("abort_done", cnt, 0);
      for (int i = 0; i < DEPTH; i++)
         check($sformatf("abort[%0d]", i), 32'(mem[i]),
               (i < 2) ? 32'(ref_op(2'b01, pre[i], 0)) : 32'(pre[i]));
      @(posedge clk);
      #1;

      clear_req = 1'b1;
      @(posedge clk);
      #1;
      clear_req = 1'b0;
      cnt = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (ram_clear) cnt++;
      end
      check("clr_pulse", cnt, 1);
      for (int i = 0; i < DEPTH; i++)
         check($sformatf("clr[%0d]", i), 32'(mem[i]), 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < DEPTH; i++) pre[i] = 8'h10;
      load_mem();
      run(2'b00, 8'h55, 0, dc, nd, nb);
      verify("pass10", 2'b00, 8'h55);

      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < DEPTH; i++) pre[i] = 8'($urandom);
         o = 2'($urandom);
         k = 8'($urandom);
         g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 22)) : 0;
         load_mem();
         run(o, k, g, dc, nd, nb);
         timing($sformatf("rnd%0d", r), dc, nd, nb);
         verify($sformatf("rnd%0d", r), o, k);
      end

      check("invariants", viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
